multdiv_controller: RTL and testbench

MULTDIV_CONTROLLER -- requirements
Module: multdiv_controller

---
 rtl/multdiv_pkg.sv | 19 +
 rtl/multdiv_controller_if.sv | 32 +++
 rtl/multdiv_counter.sv | 22 ++
 rtl/multdiv_controller.sv | 94 +++++++++
 tb/tb_multdiv_controller.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared constants for the multiply/divide sequencing controller: state
// encoding, default settle latencies and counter width.
package multdiv_pkg;

  localparam int CNT_W        = 6;
  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 16;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN_MULT = 2'd1;
  localparam logic [1:0] RUN_DIV  = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  // Counter preload for a latency: the capture edge is the one that sees zero.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/multdiv_controller_if.sv
// Request/operand/result bundle between a requester+datapath and the
// multiply/divide controller.
interface multdiv_controller_if;

  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] mult_result;
  logic        mult_exception;
  logic [31:0] div_result;
  logic        div_exception;
  logic [31:0] op_A;
  logic [31:0] op_B;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_inputRDY;
  logic        data_resultRDY;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output mult_result, mult_exception, div_result, div_exception,
    input  op_A, op_B, data_result, data_exception, data_inputRDY, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  mult_result, mult_exception, div_result, div_exception,
    output op_A, op_B, data_result, data_exception, data_inputRDY, data_resultRDY
  );

endinterface

// File: rtl/multdiv_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module multdiv_counter
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                count <= '0;
    else if (load)            count <= load_val;
    else if (dec && !zero)    count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/multdiv_controller.sv
// Sequences an external combinational multiplier/divider: latches operands,
// waits a fixed settle time, then captures the result with a one-cycle pulse.
module multdiv_controller
  import multdiv_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  multdiv_controller_if.slave  bus
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             launch_mult, launch_div, div_zero, running, finish, load;
  logic [CNT_W-1:0] load_val;
  logic             rdy_q;

  always_comb begin
    launch_mult = bus.ctrl_MULT;
    launch_div  = bus.ctrl_DIV && !bus.ctrl_MULT;
    div_zero    = launch_div && (bus.data_operandB[15:0] == 16'd0);
    running     = (state == RUN_MULT) || (state == RUN_DIV);
    load        = launch_mult || launch_div;
    // Any new request on this edge aborts the in-flight capture.
    finish      = running && cnt_zero && !load;
    load_val    = '0;
    if (launch_mult)                load_val = lat_load(MULT_LAT);
    else if (launch_div && !div_zero) load_val = lat_load(DIV_LAT);
  end

  multdiv_counter u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (running && !load),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (launch_mult) begin
      state <= RUN_MULT;
    end else if (launch_div) begin
      state <= div_zero ? DONE : RUN_DIV;
    end else begin
      case (state)
        RUN_MULT, RUN_DIV: if (cnt_zero) state <= DONE;
        DONE:              state <= IDLE;
        default:           state <= IDLE;
      endcase
    end
  end

  // Operands stay frozen between launches so the datapath settles on stable inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.op_A <= '0;
      bus.op_B <= '0;
    end else if (load) begin
      bus.op_A <= bus.data_operandA;
      bus.op_B <= bus.data_operandB;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      rdy_q              <= 1'b0;
    end else begin
      rdy_q <= div_zero || finish;
      if (div_zero) begin
        bus.data_result    <= '0;
        bus.data_exception <= 1'b1;
      end else if (finish && state == RUN_MULT) begin
        bus.data_result    <= bus.mult_result;
        bus.data_exception <= bus.mult_exception;
      end else if (finish) begin
        bus.data_result    <= bus.div_result;
        bus.data_exception <= bus.div_exception;
      end
    end
  end

  assign bus.data_resultRDY = rdy_q;
  assign bus.data_inputRDY  = (state == IDLE) || (state == DONE);

endmodule

// File: tb/tb_multdiv_controller.sv
// Scoreboard bench for multdiv_controller with a behavioural mult/div datapath
// that computes from the latched op_A/op_B.
module tb_multdiv_controller;
  import multdiv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct { int cyc; logic [31:0] res; logic exc; } exp_t;
  exp_t sb[$];

  multdiv_controller_if bus();

  multdiv_controller #(.MULT_LAT(4), .DIV_LAT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural datapath driven from the controller's latched operands.
  logic [63:0] prod;
  logic [31:0] bdiv;
  always_comb begin
    prod               = {{32{bus.op_A[31]}}, bus.op_A} * {{32{bus.op_B[31]}}, bus.op_B};
    bus.mult_result    = prod[31:0];
    bus.mult_exception = (prod[63:32] != {32{prod[31]}});
    bdiv               = {{16{bus.op_B[15]}}, bus.op_B[15:0]};
    bus.div_result     = '0;
    bus.div_exception  = 1'b1;
    if (bdiv != 32'd0) begin
      bus.div_result    = $signed(bus.op_A) / $signed(bdiv);
      bus.div_exception = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Completion monitor: every pulse must match the oldest outstanding launch.
  always @(negedge clock) begin
    if (bus.data_resultRDY) begin
      if (sb.size() == 0) begin
        chk("spurious_rdy", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdy_cycle", 64'(cyc), 64'(e.cyc));
        chk("result", {32'd0, bus.data_result}, {32'd0, e.res});
        chk("exception", {63'd0, bus.data_exception}, {63'd0, e.exc});
      end
    end
  end

  task automatic launch(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input bit want, input int lat, input logic [31:0] er, input logic ee);
    exp_t e;
    @(negedge clock);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    sb.delete();
    if (want) begin
      e.cyc = cyc + lat;
      e.res = er;
      e.exc = ee;
      sb.push_back(e);
    end
  endtask

  initial begin
    int low_cnt;
    bus.ctrl_MULT      = 1'b0;
    bus.ctrl_DIV       = 1'b0;
    bus.data_operandA  = '0;
    bus.data_operandB  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_op_A", {32'd0, bus.op_A}, 64'd0);
    chk("rst_op_B", {32'd0, bus.op_B}, 64'd0);
    chk("rst_result", {32'd0, bus.data_result}, 64'd0);
    chk("rst_exc", {63'd0, bus.data_exception}, 64'd0);
    chk("rst_resultRDY", {63'd0, bus.data_resultRDY}, 64'd0);
    chk("rst_inputRDY", {63'd0, bus.data_inputRDY}, 64'd1);
    @(negedge clock);
    reset = 1'b0;

    // Multiply 7 * -3
    launch(1, 0, 32'd7, 32'hFFFF_FFFD, 1, 4, 32'hFFFF_FFEB, 1'b0);
    chk("mult_op_A_latched", {32'd0, bus.op_A}, 64'd7);
    repeat (8) @(posedge clock);
    #1;
    chk("hold_result", {32'd0, bus.data_result}, 64'hFFFF_FFEB);
    chk("idle_inputRDY", {63'd0, bus.data_inputRDY}, 64'd1);

    // Divide 100 / 7, inputRDY low for the 16 settle cycles
    launch(0, 1, 32'd100, 32'd7, 1, 16, 32'd14, 1'b0);
    low_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (!bus.data_inputRDY) low_cnt++;
    end
    chk("div_busy_cycles", 64'(low_cnt), 64'd16);
    @(negedge clock);
    chk("div_inputRDY_back", {63'd0, bus.data_inputRDY}, 64'd1);
    repeat (4) @(posedge clock);

    // Divide by zero in the low half of B
    launch(0, 1, 32'd5, 32'h0001_0000, 1, 0, 32'd0, 1'b1);
    repeat (6) @(posedge clock);

    // Divide aborted by a multiply at cycle 5
    launch(0, 1, 32'd100, 32'd7, 1, 16, 32'd14, 1'b0);
    repeat (4) @(posedge clock);
    launch(1, 0, 32'd3, 32'd4, 1, 4, 32'd12, 1'b0);
    repeat (20) @(posedge clock);

    // Simultaneous requests: multiply wins
    launch(1, 1, 32'd6, 32'd2, 1, 4, 32'd12, 1'b0);
    repeat (20) @(posedge clock);

    // Multiply overflow: 2^16 * 2^16
    launch(1, 0, 32'h0001_0000, 32'h0001_0000, 1, 4, 32'd0, 1'b1);
    repeat (8) @(posedge clock);

    // Asynchronous reset in the middle of a divide
    launch(0, 1, 32'd100, 32'd7, 0, 16, 32'd0, 1'b0);
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_op_A", {32'd0, bus.op_A}, 64'd0);
    chk("arst_op_B", {32'd0, bus.op_B}, 64'd0);
    chk("arst_result", {32'd0, bus.data_result}, 64'd0);
    chk("arst_exc", {63'd0, bus.data_exception}, 64'd0);
    chk("arst_inputRDY", {63'd0, bus.data_inputRDY}, 64'd1);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd9;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ignores_req", {32'd0, bus.op_A}, 64'd0);
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    reset         = 1'b0;
    repeat (25) @(posedge clock);
    #1;
    chk("post_rst_inputRDY", {63'd0, bus.data_inputRDY}, 64'd1);

    chk("pending_completions", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
